reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/avr_dbg_pkg.sv | 35 +++
 rtl/reg_dump_reader.sv | 126 ++++++++++++
 tb/tb_reg_dump_reader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_dbg_pkg.sv
// Shared definitions for the AVR debug-link blocks: register address width,
// frame header marker, dump FSM state encoding and the count clamp helper.
package avr_dbg_pkg;

  // Register file address width (32 registers).
  localparam int ADDR_W = 5;

  // Width of the requested register count.
  localparam int CNT_W = 6;

  // Default frame start marker.
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Dump frame FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADR  = 3'd2,
    ST_CNT  = 3'd3,
    ST_DATA = 3'd4,
    ST_SUM  = 3'd5
  } dump_state_e;

  // Limit a requested count to the number of registers actually present.
  function automatic logic [CNT_W-1:0] clamp_count(
    input logic [CNT_W-1:0] req,
    input logic [CNT_W:0]   max_cnt
  );
    if ({1'b0, req} > max_cnt) begin
      return max_cnt[CNT_W-1:0];
    end
    return req;
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: on a start request, streams one frame over a byte-wide
// debug link: header, first address, effective count, register bytes and an
// 8-bit additive checksum of the register bytes.
//
// Handshake on the debug link: a byte moves on every posedge where
// tx_valid && tx_ready. Once tx_valid rises it stays high until the checksum
// byte has moved, and tx_data is held constant while tx_valid=1 and
// tx_ready=0. tx_ready without tx_valid does nothing.
module reg_dump_reader
  import avr_dbg_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [7:0]        rf_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output dump_state_e       state_dbg
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(NUM_REGS);

  dump_state_e       state;
  logic [ADDR_W-1:0] addr_q;     // first address latched with start
  logic [CNT_W-1:0]  eff_q;      // clamped register count for this frame
  logic [CNT_W-1:0]  remain_q;   // data bytes still to load after the one in tx_data
  logic [7:0]        sum_q;      // running checksum of loaded data bytes
  logic              xfer;

  assign xfer      = tx_valid & tx_ready;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Frame sequencer: each byte is loaded into tx_data on the transfer of the
  // previous one, so the link sees back-to-back bytes with no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
      rf_addr  <= '0;
      addr_q   <= '0;
      eff_q    <= '0;
      remain_q <= '0;
      sum_q    <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= first_addr;
            eff_q    <= clamp_count(count, MAX_CNT);
            rf_addr  <= first_addr;
            sum_q    <= 8'h00;
            tx_data  <= HDR_BYTE;
            tx_valid <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            tx_data <= {{(8 - ADDR_W){1'b0}}, addr_q};
            state   <= ST_ADR;
          end
        end
        ST_ADR: begin
          if (xfer) begin
            tx_data <= {{(8 - CNT_W){1'b0}}, eff_q};
            state   <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (xfer) begin
            if (eff_q == '0) begin
              tx_data <= sum_q;
              state   <= ST_SUM;
            end else begin
              // First data byte: capture the register now, never re-read.
              tx_data  <= rf_data;
              sum_q    <= sum_q + rf_data;
              rf_addr  <= rf_addr + 1'b1;
              remain_q <= eff_q - 1'b1;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            if (remain_q == '0) begin
              tx_data <= sum_q;
              state   <= ST_SUM;
            end else begin
              tx_data  <= rf_data;
              sum_q    <= sum_q + rf_data;
              rf_addr  <= rf_addr + 1'b1;
              remain_q <= remain_q - 1'b1;
            end
          end
        end
        ST_SUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: directed frames plus randomized frames, each
// checked byte-by-byte against a frame built from the register contents.
module tb_reg_dump_reader;
  import avr_dbg_pkg::*;

  localparam int NUM_REGS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [5:0]  count;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  dump_state_e state_dbg;

  logic [7:0]  regs [NUM_REGS];
  assign rf_data = regs[rf_addr];

  reg_dump_reader #(.NUM_REGS(NUM_REGS), .HDR_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int  last_xfer_cyc = 0;
  bit  prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  bit  mon_en = 0;
  int  ready_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Link monitor: samples on the falling edge, i.e. the values the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 0;
    end else begin
      check("valid_eq_busy", {31'd0, tx_valid}, {31'd0, busy});
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        last_xfer_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = toggle each cycle, 2 = random
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic randomize_regs();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference model: build the expected frame from the register contents,
  // then request the frame and check the header arrives one cycle later.
  task automatic launch(input logic [4:0] fa, input logic [5:0] cn);
    int eff;
    int sum;
    eff = (int'(cn) > NUM_REGS) ? NUM_REGS : int'(cn);
    sum = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back({3'd0, fa});
    exp_q.push_back(8'(eff));
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(regs[(int'(fa) + i) % NUM_REGS]);
      sum += int'(regs[(int'(fa) + i) % NUM_REGS]);
    end
    exp_q.push_back(8'(sum % 256));
    start      = 1'b1;
    first_addr = fa;
    count      = cn;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hdr_valid", {31'd0, tx_valid}, 32'd1);
    check("hdr_data", {24'd0, tx_data}, 32'hA5);
    check("busy_on", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done, optionally overwrite a captured register while
  // the link is stalled, then compare the received frame with the model.
  task automatic wait_done(input bit do_write);
    int n;
    bit got;
    bit wr_done;
    n = 0;
    got = 0;
    wr_done = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      n++;
      if (do_write && !wr_done && state_dbg == ST_DATA && !tx_ready && rf_addr == 5'd1) begin
        regs[0] = 8'hEE;
        wr_done = 1;
      end
      if (done) got = 1;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("done_latency", 32'(cyc - last_xfer_cyc), 32'd1);
      check("idle_at_done", {31'd0, busy}, 32'd0);
    end
    check("frame_len", 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check("frame_byte", {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
    end
    rx_q.delete();
    exp_q.delete();
    if (do_write) check("stall_write_hit", {31'd0, wr_done}, 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit hit;
    rst        = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    count      = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {27'd0, rf_addr}, 32'd0);
    rst    = 1'b0;
    mon_en = 1;
    next_cycle();

    // Basic dump
    regs[0] = 8'h10; regs[1] = 8'h20; regs[2] = 8'h30;
    launch(5'd0, 6'd3);
    wait_done(0);
    next_cycle();

    // Address wrap
    regs[30] = 8'hFF; regs[31] = 8'h01; regs[0] = 8'h02; regs[1] = 8'h03;
    launch(5'd30, 6'd4);
    wait_done(0);
    next_cycle();

    // Backpressure with a register write while stalled
    ready_mode = 1;
    regs[0] = 8'h10; regs[1] = 8'h20; regs[2] = 8'h30;
    launch(5'd0, 6'd3);
    wait_done(1);
    ready_mode = 0;
    next_cycle();

    // Zero count and clamp
    launch(5'd7, 6'd0);
    wait_done(0);
    next_cycle();
    randomize_regs();
    launch(5'd5, 6'd40);
    wait_done(0);
    next_cycle();

    // start while busy is ignored, nothing queued
    launch(5'd2, 6'd5);
    start = 1'b1; first_addr = 5'd9; count = 6'd1;
    next_cycle();
    start = 1'b0;
    wait_done(0);
    next_cycle();
    check("no_requeue_busy", {31'd0, busy}, 32'd0);
    check("no_requeue_valid", {31'd0, tx_valid}, 32'd0);

    // Back-to-back: start on the done cycle
    launch(5'd3, 6'd2);
    wait_done(0);
    launch(5'd4, 6'd3);
    wait_done(0);
    next_cycle();

    // Reset mid-frame, together with start
    launch(5'd0, 6'd10);
    n = 0;
    hit = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      if (state_dbg == ST_DATA) hit = 1;
    end
    check("reach_data", {31'd0, hit}, 32'd1);
    next_cycle();
    rst = 1'b1; start = 1'b1;
    next_cycle();
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_addr", {27'd0, rf_addr}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0;
    rx_q.delete();
    exp_q.delete();
    next_cycle();
    launch(5'd0, 6'd10);
    wait_done(0);
    next_cycle();

    // Randomized frames
    for (int k = 0; k < 25; k++) begin
      randomize_regs();
      ready_mode = $urandom_range(0, 2);
      launch(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
      wait_done(0);
      if ($urandom_range(0, 1) == 1) next_cycle();
    end
    ready_mode = 0;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
